// File: rtl/demux_1xn_nbit_stream_if.sv
// Stream bundle for the 1-to-M demultiplexer: one input stream, M packed output
// channels and the saturating drop counter.
interface demux_1xn_nbit_stream_if #(
    parameter int NUM_OF_OUTPUTS = 5,
    parameter int OUTPUT_WIDTH   = 4,
    parameter int SEL_WIDTH      = $clog2(NUM_OF_OUTPUTS),
    parameter int DROP_CNT_WIDTH = 8
);
    logic [OUTPUT_WIDTH-1:0]                out_data_unused_guard;
    logic [OUTPUT_WIDTH-1:0]                in_data;
    logic [SEL_WIDTH-1:0]                   in_sel;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [OUTPUT_WIDTH*NUM_OF_OUTPUTS-1:0] out_data;
    logic [NUM_OF_OUTPUTS-1:0]              out_valid;
    logic [NUM_OF_OUTPUTS-1:0]              out_ready;
    logic [DROP_CNT_WIDTH-1:0]              drop_cnt;

    assign out_data_unused_guard = '0;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );
endinterface

// File: rtl/demux_1xn_nbit_stream.sv
// Registered 1-to-M stream demultiplexer: one holding register per channel with
// valid/ready flow control; out-of-range selects are accepted, dropped and counted.
module demux_1xn_nbit_stream #(
    parameter int NUM_OF_OUTPUTS = 5,
    parameter int OUTPUT_WIDTH   = 4,
    parameter int SEL_WIDTH      = $clog2(NUM_OF_OUTPUTS),
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1xn_nbit_stream_if.slave bus
);
    localparam logic [SEL_WIDTH:0] NUM_SEL = (SEL_WIDTH+1)'(NUM_OF_OUTPUTS);

    logic                                           sel_ok;
    logic                                           sel_rdy;
    logic                                           accept;
    logic [NUM_OF_OUTPUTS-1:0]                      ch_rdy;
    logic [NUM_OF_OUTPUTS-1:0]                      ch_vld;
    logic [NUM_OF_OUTPUTS-1:0]                      load;
    logic [NUM_OF_OUTPUTS-1:0][OUTPUT_WIDTH-1:0]    ch_data;
    logic [DROP_CNT_WIDTH-1:0]                      drop_q;

    assign sel_ok = {1'b0, bus.in_sel} < NUM_SEL;

    // Looked up by compare rather than indexing so an out-of-range select never reads past the array.
    always_comb begin
        sel_rdy = 1'b0;
        for (int k = 0; k < NUM_OF_OUTPUTS; k++)
            if (bus.in_sel == SEL_WIDTH'(k)) sel_rdy = ch_rdy[k];
    end

    assign bus.in_ready = rst_n & (~sel_ok | sel_rdy);
    assign accept       = bus.in_valid & bus.in_ready;

    generate
        for (genvar k = 0; k < NUM_OF_OUTPUTS; k++) begin : g_ch
            logic [OUTPUT_WIDTH-1:0] data_q;
            logic                    vld_q;

            assign ch_rdy[k] = ~vld_q | bus.out_ready[k];
            assign load[k]   = accept & (bus.in_sel == SEL_WIDTH'(k));

            // Load beats drain so back-to-back words stream without a bubble.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else if (load[k]) begin
                    data_q <= bus.in_data;
                    vld_q  <= 1'b1;
                end else if (vld_q & bus.out_ready[k]) begin
                    vld_q  <= 1'b0;
                end
            end

            assign ch_data[k] = data_q;
            assign ch_vld[k]  = vld_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= '0;
        else if (accept & ~sel_ok & (drop_q != '1))
            drop_q <= drop_q + 1'b1;
    end

    assign bus.out_data  = ch_data;
    assign bus.out_valid = ch_vld;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_demux_1xn_nbit_stream.sv
// Bench for demux_1xn_nbit_stream: vector table, directed corner sequences and a
// randomized run against per-channel queue scoreboards.
module tb_demux_1xn_nbit_stream;
    localparam int M  = 5;
    localparam int W  = 4;
    localparam int SW = 3;
    localparam int DW = 8;

    typedef struct {
        logic          vld;
        logic [SW-1:0] sel;
        logic [W-1:0]  data;
        logic [M-1:0]  ordy;
        logic          exp_irdy;
        logic [M-1:0]  exp_ovld;
        logic [M*W-1:0] exp_odata;
        logic [DW-1:0] exp_drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    demux_1xn_nbit_stream_if #(.NUM_OF_OUTPUTS(M), .OUTPUT_WIDTH(W), .DROP_CNT_WIDTH(DW)) bus ();

    demux_1xn_nbit_stream #(.NUM_OF_OUTPUTS(M), .OUTPUT_WIDTH(W), .DROP_CNT_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d,
                                input logic [M-1:0] r, input logic ir, input logic [M-1:0] ov,
                                input logic [M*W-1:0] od, input logic [DW-1:0] dc);
        vec_t t;
        t.vld = v; t.sel = s; t.data = d; t.ordy = r; t.exp_irdy = ir;
        t.exp_ovld = ov; t.exp_odata = od; t.exp_drop = dc;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d, input logic [M-1:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [W-1:0] q[M][$];
        int          drops_m;
        int          hs;

        drive(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
        bus.in_valid = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0);

        // Routing, backpressure, drain+load and out-of-range drops, one clock per row.
        tbl.push_back(mk(1, 0, 4'hA, 5'h1F, 1, 5'h01, 20'h0000A, 0));
        tbl.push_back(mk(1, 1, 4'hB, 5'h1F, 1, 5'h02, 20'h000BA, 0));
        tbl.push_back(mk(1, 2, 4'hC, 5'h1F, 1, 5'h04, 20'h00CBA, 0));
        tbl.push_back(mk(1, 3, 4'hD, 5'h1F, 1, 5'h08, 20'h0DCBA, 0));
        tbl.push_back(mk(1, 4, 4'hE, 5'h1F, 1, 5'h10, 20'hEDCBA, 0));
        tbl.push_back(mk(0, 0, 4'h0, 5'h1F, 0, 5'h00, 20'hEDCBA, 0));
        tbl.push_back(mk(1, 2, 4'h3, 5'h1B, 1, 5'h04, 20'hED3BA, 0));
        tbl.push_back(mk(1, 2, 4'h7, 5'h1B, 0, 5'h04, 20'hED3BA, 0));
        tbl.push_back(mk(1, 1, 4'h9, 5'h1B, 1, 5'h06, 20'hED39A, 0));
        tbl.push_back(mk(1, 2, 4'h7, 5'h1F, 1, 5'h04, 20'hED79A, 0));
        tbl.push_back(mk(0, 0, 4'h0, 5'h1B, 0, 5'h04, 20'hED79A, 0));
        tbl.push_back(mk(0, 0, 4'h0, 5'h1F, 0, 5'h00, 20'hED79A, 0));
        tbl.push_back(mk(1, 4, 4'h1, 5'h0F, 1, 5'h10, 20'h1D79A, 0));
        tbl.push_back(mk(1, 4, 4'h5, 5'h1F, 1, 5'h10, 20'h5D79A, 0));
        tbl.push_back(mk(1, 5, 4'hF, 5'h0F, 1, 5'h10, 20'h5D79A, 1));
        tbl.push_back(mk(1, 6, 4'hF, 5'h0F, 1, 5'h10, 20'h5D79A, 2));
        tbl.push_back(mk(1, 7, 4'hF, 5'h0F, 1, 5'h10, 20'h5D79A, 3));
        tbl.push_back(mk(0, 0, 4'h0, 5'h1F, 0, 5'h00, 20'h5D79A, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy);
            #1;
            if (tbl[i].vld) chk($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_irdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ovld));
            chk($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].exp_odata));
            chk($sformatf("tbl%0d_drop_cnt", i), 32'(bus.drop_cnt), 32'(tbl[i].exp_drop));
        end

        // Ten back-to-back words into channel 4 with the sink always ready.
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 3'd4, 4'(i + 1), 5'h1F);
            #1;
            if (bus.in_ready) hs++;
            @(posedge clk);
            #1;
            chk("b2b_data", 32'(bus.out_data[4*W +: W]), 32'(i + 1));
            chk("b2b_valid", 32'(bus.out_valid[4]), 32'h1);
        end
        chk("b2b_handshakes", 32'(hs), 32'd10);

        // Drop counter saturation: 3 already counted, 300 more requested in total.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(1'b1, 3'(5 + $urandom_range(2)), 4'($urandom), 5'h1F);
            @(posedge clk);
            #1;
            if (i == 250) chk("drop_cnt_254", 32'(bus.drop_cnt), 32'hFE);
        end
        chk("drop_cnt_sat", 32'(bus.drop_cnt), 32'hFF);
        chk("drop_out_valid", 32'(bus.out_valid), 32'h0);

        // Reset asserted mid-stream with channels 1 and 2 holding words.
        @(negedge clk);
        drive(1'b1, 3'd1, 4'h6, 5'h00);
        @(negedge clk);
        drive(1'b1, 3'd2, 4'h8, 5'h00);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h06);
        @(negedge clk);
        drive(1'b1, 3'd0, 4'h1, 5'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("async_rst_out_data", 32'(bus.out_data), 32'h0);
        chk("async_rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 5'h1F);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_out_data", 32'(bus.out_data), 32'h0);

        // Randomized traffic against per-channel queues of capacity one.
        drops_m = 0;
        for (int c = 0; c < 10000; c++) begin
            logic          iv, exp_ir, acc;
            logic [SW-1:0] is;
            logic [W-1:0]  id;
            logic [M-1:0]  orr, exp_v;
            logic [M*W-1:0] exp_d, act_d;
            @(negedge clk);
            iv  = ($urandom_range(3) != 0);
            is  = 3'($urandom_range(7));
            id  = 4'($urandom);
            orr = 5'($urandom);
            drive(iv, is, id, orr);
            #1;
            if (is >= M) exp_ir = 1'b1;
            else         exp_ir = (q[is].size() == 0) || orr[is];
            if (iv) chk("rand_in_ready", 32'(bus.in_ready), 32'(exp_ir));
            acc = iv && exp_ir;
            @(posedge clk);
            for (int k = 0; k < M; k++)
                if (q[k].size() > 0 && orr[k]) void'(q[k].pop_front());
            if (acc) begin
                if (is < M) q[is].push_back(id);
                else if (drops_m < 255) drops_m++;
            end
            #1;
            exp_v = '0; exp_d = '0; act_d = '0;
            for (int k = 0; k < M; k++)
                if (q[k].size() > 0) begin
                    exp_v[k] = 1'b1;
                    exp_d[k*W +: W] = q[k][0];
                    act_d[k*W +: W] = bus.out_data[k*W +: W];
                end
            chk("rand_out_valid", 32'(bus.out_valid), 32'(exp_v));
            chk("rand_out_data", 32'(act_d), 32'(exp_d));
            chk("rand_drop_cnt", 32'(bus.drop_cnt), 32'(drops_m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
